// File: rtl/fp16_add_sequencer_if.sv
// fp16_add_sequencer_if: operand/result handshake bundle for the half-precision adder.
interface fp16_add_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        busy;
    modport slave (input in_valid, a, b, out_ready, output in_ready, out_valid, sum, busy);
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, sum, busy);
endinterface

// File: rtl/fp16_add_sequencer.sv
// fp16_add_sequencer: multi-cycle truncating half-precision adder (denormals flushed to zero).
module fp16_add_sequencer #(
    parameter logic [15:0] NAN_CODE = 16'h7E00
) (
    input logic clk,
    input logic reset,
    fp16_add_if.slave io
);
    localparam logic [2:0] IDLE = 3'd0, ALIGN = 3'd1, ADD = 3'd2, NORM = 3'd3, DONE = 3'd4;
    logic [2:0]  state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic        sign_q, sign_d, sub_q, sub_d;
    logic [4:0]  exp_q, exp_d;
    logic [10:0] big_q, big_d, sml_q, sml_d;
    logic [11:0] res_q, res_d;
    logic        swap, nan, inf_sign;
    logic [15:0] hi, lo;
    logic [10:0] hi_sig, lo_sig, dif11;
    logic [4:0]  diff;
    always_comb begin
        swap     = b_q[14:0] > a_q[14:0];
        hi       = swap ? b_q : a_q;
        lo       = swap ? a_q : b_q;
        hi_sig   = (hi[14:10] == 5'd0) ? 11'd0 : {1'b1, hi[9:0]};
        lo_sig   = (lo[14:10] == 5'd0) ? 11'd0 : {1'b1, lo[9:0]};
        diff     = hi[14:10] - lo[14:10];
        nan      = (a_q[14:10] == 5'h1F && a_q[9:0] != 10'd0) || (b_q[14:10] == 5'h1F && b_q[9:0] != 10'd0) ||
                   (a_q[14:10] == 5'h1F && b_q[14:10] == 5'h1F && a_q[15] != b_q[15]);
        inf_sign = (a_q[14:10] == 5'h1F) ? a_q[15] : b_q[15];
        // subtraction keeps only 11 bits: the carry out of the two's complement add is dropped
        dif11    = big_q + ~sml_q + 11'd1;
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        big_d    = big_q;
        sml_d    = sml_q;
        res_d    = res_q;
        case (state_q)
            IDLE: if (io.in_valid) begin
                a_d     = io.a;
                b_d     = io.b;
                state_d = ALIGN;
            end
            ALIGN: if (a_q[14:10] == 5'h1F || b_q[14:10] == 5'h1F) begin
                sum_d   = nan ? NAN_CODE : {inf_sign, 15'h7C00};
                state_d = DONE;
            end else begin
                big_d   = hi_sig;
                sml_d   = lo_sig >> diff;
                exp_d   = hi[14:10];
                sign_d  = hi[15];
                sub_d   = a_q[15] != b_q[15];
                state_d = ADD;
            end
            ADD: begin
                res_d   = sub_q ? {1'b0, dif11} : {1'b0, big_q} + {1'b0, sml_q};
                state_d = NORM;
            end
            NORM: if (res_q == 12'd0) begin
                sum_d   = 16'h0000;
                state_d = DONE;
            end else if (res_q[11]) begin
                sum_d   = (exp_q == 5'd30) ? {sign_q, 15'h7C00} : {sign_q, exp_q + 5'd1, res_q[10:1]};
                state_d = DONE;
            end else if (res_q[10]) begin
                sum_d   = {sign_q, exp_q, res_q[9:0]};
                state_d = DONE;
            end else begin
                res_d   = res_q << 1;
                exp_d   = exp_q - 5'd1;
                sum_d   = (exp_q == 5'd1) ? {sign_q, 15'h0000} : sum_q;
                state_d = (exp_q == 5'd1) ? DONE : NORM;
            end
            DONE: state_d = io.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            sum_q   <= 16'h0000;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= 5'd0;
            big_q   <= 11'd0;
            sml_q   <= 11'd0;
            res_q   <= 12'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            big_q   <= big_d;
            sml_q   <= sml_d;
            res_q   <= res_d;
        end
    end
    assign io.in_ready  = state_q == IDLE;
    assign io.out_valid = state_q == DONE;
    assign io.busy      = state_q != IDLE;
    assign io.sum       = sum_q;
endmodule
